// File: rtl/scroll_text_controller.sv
// Drives the 8-digit scrolling seven-segment display: buffers a short hex message
// and scrolls it in from the left using timed clear/write/shift strobes.
module scroll_text_controller #(
    parameter int DEPTH       = 16,
    parameter int STEP_CYCLES = 25000000,
    parameter int GAP         = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [3:0]                   wr_data,
    input  logic                         wr_blank,
    input  logic                         clear_msg,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop_mode,
    output logic [3:0]                   seg_data,
    output logic                         seg_off,
    output logic                         seg_write,
    output logic                         seg_shift,
    output logic                         seg_clear,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   msg_len,
    output logic                         buf_full
);

    localparam int IW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(STEP_CYCLES);

    localparam logic [TW-1:0] TICK_FIRE = TW'(STEP_CYCLES - 2);
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CLR  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_PAD  = 2'd3;

    logic [4:0]    msg_buf [DEPTH];
    logic [1:0]    state;
    logic [IW-1:0] index;
    logic [TW-1:0] tick;
    logic [7:0]    pad_cnt;
    logic          loop_q;

    logic          start_ok;
    logic          do_clear;
    logic          do_write;
    logic          step;
    logic          last_entry;
    logic [4:0]    cur_entry;

    assign start_ok   = (state == S_IDLE) && start && (msg_len != '0);
    assign do_clear   = (state == S_IDLE) && !start_ok && clear_msg;
    assign do_write   = (state == S_IDLE) && !start_ok && !clear_msg && wr_en && !buf_full;
    // Strobes are registered, so the step is decided one cycle before the tick wraps.
    assign step       = (tick == TICK_FIRE);
    assign last_entry = (LW'(index) == (msg_len - LW'(1)));
    assign cur_entry  = msg_buf[index];

    always_ff @(posedge clk) begin
        if (do_write) begin
            msg_buf[msg_len[IW-1:0]] <= {wr_blank, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            msg_len   <= '0;
            buf_full  <= 1'b0;
            seg_data  <= 4'd0;
            seg_off   <= 1'b0;
            seg_write <= 1'b0;
            seg_shift <= 1'b0;
            seg_clear <= 1'b0;
            tick      <= '0;
            pad_cnt   <= 8'd0;
            index     <= '0;
            loop_q    <= 1'b0;
        end else begin
            seg_data  <= 4'd0;
            seg_off   <= 1'b0;
            seg_write <= 1'b0;
            seg_shift <= 1'b0;
            seg_clear <= 1'b0;

            if (state == S_RUN || state == S_PAD) begin
                tick <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
            end else begin
                tick <= '0;
            end

            if (state != S_IDLE && stop) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                seg_clear <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            state     <= S_CLR;
                            busy      <= 1'b1;
                            seg_clear <= 1'b1;
                            loop_q    <= loop_mode;
                            index     <= '0;
                        end else if (do_clear) begin
                            msg_len  <= '0;
                            buf_full <= 1'b0;
                        end else if (do_write) begin
                            msg_len  <= msg_len + LW'(1);
                            buf_full <= (msg_len == LW'(DEPTH - 1));
                        end
                    end
                    S_CLR: begin
                        state <= S_RUN;
                    end
                    S_RUN: begin
                        if (step) begin
                            seg_write <= 1'b1;
                            seg_shift <= 1'b1;
                            seg_data  <= cur_entry[3:0];
                            seg_off   <= cur_entry[4];
                            if (last_entry) begin
                                index   <= '0;
                                state   <= S_PAD;
                                pad_cnt <= loop_q ? 8'(GAP) : 8'd8;
                            end else begin
                                index <= index + IW'(1);
                            end
                        end
                    end
                    S_PAD: begin
                        // Leave PAD only once the last blank shift has been shown,
                        // so no strobe ever appears while idle.
                        if (pad_cnt == 8'd0) begin
                            state <= loop_q ? S_RUN : S_IDLE;
                            busy  <= loop_q;
                        end else if (step) begin
                            seg_shift <= 1'b1;
                            pad_cnt   <= pad_cnt - 8'd1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scroll_text_controller.sv
// Directed bench for scroll_text_controller: a load/command vector table plus
// cycle-by-cycle scroll sequences with hand-derived strobe timing.
module tb_scroll_text_controller;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_data;
    logic       wr_blank;
    logic       clear_msg;
    logic       start;
    logic       stop;
    logic       loop_mode;
    logic [3:0] seg_data;
    logic       seg_off;
    logic       seg_write;
    logic       seg_shift;
    logic       seg_clear;
    logic       busy;
    logic [2:0] msg_len;
    logic       buf_full;

    int checks = 0;
    int errors = 0;

    logic [12:0] obs;
    assign obs = {busy, seg_clear, seg_shift, seg_write, seg_off, seg_data, msg_len, buf_full};

    typedef struct {
        string       name;
        logic        r;
        logic        we;
        logic        wb;
        logic [3:0]  wd;
        logic        cm;
        logic        st;
        logic        sp;
        logic        lm;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[13];

    scroll_text_controller #(
        .DEPTH(4),
        .STEP_CYCLES(4),
        .GAP(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .wr_blank(wr_blank),
        .clear_msg(clear_msg),
        .start(start),
        .stop(stop),
        .loop_mode(loop_mode),
        .seg_data(seg_data),
        .seg_off(seg_off),
        .seg_write(seg_write),
        .seg_shift(seg_shift),
        .seg_clear(seg_clear),
        .busy(busy),
        .msg_len(msg_len),
        .buf_full(buf_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] ex(input logic b, input logic c, input logic s, input logic w,
                                       input logic o, input logic [3:0] d, input logic [2:0] len,
                                       input logic f);
        return {b, c, s, w, o, d, len, f};
    endfunction

    task automatic applyStimulus(input logic r, input logic we, input logic wb, input logic [3:0] wd,
                                 input logic cm, input logic st, input logic sp, input logic lm);
        @(negedge clk);
        rst       = r;
        wr_en     = we;
        wr_blank  = wb;
        wr_data   = wd;
        clear_msg = cm;
        start     = st;
        stop      = sp;
        loop_mode = lm;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [12:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %b expected %b (busy,clr,shift,write,off,data,len,full)",
                     name, obs, exp);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic       b;
        logic       s;
        logic       w;
        logic       o;
        logic [3:0] d;
        int         k;

        rst = 1'b1; wr_en = 1'b0; wr_data = 4'h0; wr_blank = 1'b0;
        clear_msg = 1'b0; start = 1'b0; stop = 1'b0; loop_mode = 1'b0;

        vecs[0]  = '{"reset",        1, 0, 0, 4'h0, 0, 0, 0, 0, ex(0,0,0,0,0,4'h0,3'd0,0)};
        vecs[1]  = '{"idle",         0, 0, 0, 4'h0, 0, 0, 0, 0, ex(0,0,0,0,0,4'h0,3'd0,0)};
        vecs[2]  = '{"wr1",          0, 1, 0, 4'h1, 0, 0, 0, 0, ex(0,0,0,0,0,4'h0,3'd1,0)};
        vecs[3]  = '{"wr2",          0, 1, 0, 4'h2, 0, 0, 0, 0, ex(0,0,0,0,0,4'h0,3'd2,0)};
        vecs[4]  = '{"wr3",          0, 1, 0, 4'h3, 0, 0, 0, 0, ex(0,0,0,0,0,4'h0,3'd3,0)};
        vecs[5]  = '{"wr4_full",     0, 1, 0, 4'h4, 0, 0, 0, 0, ex(0,0,0,0,0,4'h0,3'd4,1)};
        vecs[6]  = '{"wr5_dropped",  0, 1, 0, 4'h5, 0, 0, 0, 0, ex(0,0,0,0,0,4'h0,3'd4,1)};
        vecs[7]  = '{"idle_full",    0, 0, 0, 4'h0, 0, 0, 0, 0, ex(0,0,0,0,0,4'h0,3'd4,1)};
        vecs[8]  = '{"clear",        0, 0, 0, 4'h0, 1, 0, 0, 0, ex(0,0,0,0,0,4'h0,3'd0,0)};
        vecs[9]  = '{"start_empty",  0, 0, 0, 4'h0, 0, 1, 0, 0, ex(0,0,0,0,0,4'h0,3'd0,0)};
        vecs[10] = '{"wrA",          0, 1, 0, 4'hA, 0, 0, 0, 0, ex(0,0,0,0,0,4'h0,3'd1,0)};
        vecs[11] = '{"wrB",          0, 1, 0, 4'hB, 0, 0, 0, 0, ex(0,0,0,0,0,4'h0,3'd2,0)};
        vecs[12] = '{"stop_idle",    0, 0, 0, 4'h0, 0, 0, 1, 0, ex(0,0,0,0,0,4'h0,3'd2,0)};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].r, vecs[i].we, vecs[i].wb, vecs[i].wd,
                          vecs[i].cm, vecs[i].st, vecs[i].sp, vecs[i].lm);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // One-shot {A,B}; wr/clear/start issued mid-scroll must be ignored.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("os_start", ex(1,1,0,0,0,4'h0,3'd2,0));
        for (int off = 1; off <= 41; off++) begin
            applyStimulus(1'b0, off == 2, 1'b0, 4'h9, off == 3, off == 5, 1'b0, off == 5);
            b = (off <= 40);
            s = (off % 4 == 0);
            w = (off == 4) || (off == 8);
            d = (off == 4) ? 4'hA : (off == 8) ? 4'hB : 4'h0;
            checkOutput($sformatf("os_%0d", off), ex(b,0,s,w,0,d,3'd2,0));
        end

        // Loop mode, GAP=2, message {1, blank, 3}.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lp_clear", ex(0,0,0,0,0,4'h0,3'd0,0));
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lp_loaded", ex(0,0,0,0,0,4'h0,3'd3,0));
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("lp_start", ex(1,1,0,0,0,4'h0,3'd3,0));
        for (int off = 1; off <= 47; off++) begin
            idleCycle();
            s = (off % 4 == 0);
            w = 1'b0; o = 1'b0; d = 4'h0;
            if (s) begin
                k = (off / 4 - 1) % 5;
                w = (k < 3);
                o = (k == 1);
                d = (k == 0) ? 4'h1 : (k == 2) ? 4'h3 : 4'h0;
            end
            checkOutput($sformatf("lp_%0d", off), ex(1,0,s,w,o,d,3'd3,0));
        end
        // Stop lands on the cycle that would otherwise carry a step.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("lp_stop_tick", ex(0,1,0,0,0,4'h0,3'd3,0));
        idleCycle();
        checkOutput("lp_after_stop", ex(0,0,0,0,0,4'h0,3'd3,0));

        // Restart one-shot from index 0, then reset in the middle of PAD.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rs_start", ex(1,1,0,0,0,4'h0,3'd3,0));
        for (int off = 1; off <= 17; off++) begin
            idleCycle();
            s = (off % 4 == 0);
            w = (off == 4) || (off == 8) || (off == 12);
            o = (off == 8);
            d = (off == 4) ? 4'h1 : (off == 12) ? 4'h3 : 4'h0;
            checkOutput($sformatf("rs_%0d", off), ex(1,0,s,w,o,d,3'd3,0));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rs_reset", ex(0,0,0,0,0,4'h0,3'd0,0));
        for (int off = 0; off < 10; off++) begin
            idleCycle();
            checkOutput($sformatf("rs_quiet_%0d", off), ex(0,0,0,0,0,4'h0,3'd0,0));
        end

        // start and clear_msg together: scroll wins and the buffer survives.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sc_load", ex(0,0,0,0,0,4'h0,3'd1,0));
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("sc_start", ex(1,1,0,0,0,4'h0,3'd1,0));
        for (int off = 1; off <= 5; off++) begin
            idleCycle();
            w = (off == 4);
            d = (off == 4) ? 4'h5 : 4'h0;
            checkOutput($sformatf("sc_%0d", off), ex(1,0,w,w,0,d,3'd1,0));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("sc_stop_pad", ex(0,1,0,0,0,4'h0,3'd1,0));
        idleCycle();
        checkOutput("sc_idle", ex(0,0,0,0,0,4'h0,3'd1,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scroll_text_controller.md
Name: scroll_text_controller

Overview:
Upstream driver for the 8-digit scrolling seven-segment display block. Holds a short message of hex digits loaded by software/bus logic. On command, it scrolls the message across the display by issuing timed write/shift/clear strobes. Characters enter at the leftmost digit and move right. Supports looped and one-shot scrolling.

Parameters:
DEPTH, 16, message buffer entries (digits); power of two, >=2
STEP_CYCLES, 25000000, clk cycles between scroll steps (4 Hz at 100 MHz); >=2
GAP, 8, blank steps inserted after the last digit in loop mode; 0..255

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wr_en  in  1  append one entry to the message buffer
wr_data  in  4  hex digit for the appended entry
wr_blank  in  1  appended entry is a blank (digit off)
clear_msg  in  1  empty the message buffer
start  in  1  begin scrolling
stop  in  1  abort scrolling
loop_mode  in  1  1 = repeat forever, 0 = one-shot; sampled on start
seg_data  out  4  digit to display; valid only with seg_write
seg_off  out  1  digit blank flag; valid only with seg_write
seg_write  out  1  write strobe to display
seg_shift  out  1  shift strobe to display
seg_clear  out  1  clear strobe to display
busy  out  1  high in any state other than IDLE
msg_len  out  $clog2(DEPTH+1)  number of stored entries
buf_full  out  1  msg_len == DEPTH

Behaviour:
- Reset: state IDLE; msg_len=0; all seg_* outputs 0; busy=0; tick counter=0; pad counter=0; index=0. Buffer contents are don't-care.
- All outputs are registered. Strobes are single-cycle pulses. seg_data and seg_off are 0 whenever seg_write=0.
- Buffer: DEPTH x 5 bits {blank, digit}.
  - wr_en in IDLE with msg_len<DEPTH: entry stored at index msg_len; msg_len increments next cycle.
  - wr_en when full or busy: ignored.
  - clear_msg in IDLE: msg_len=0 next cycle. Ignored when busy.
  - Same-cycle priority in IDLE: start > clear_msg > wr_en.
- States: IDLE, CLR, RUN, PAD.
- IDLE -> CLR: on start with msg_len>0. loop_mode latched; index=0. start with msg_len=0 is ignored.
- CLR (1 cycle): seg_clear=1. Tick counter cleared -> RUN.
- Tick: counter counts 0..STEP_CYCLES-1 from the cycle after CLR and wraps. A step fires when the counter equals STEP_CYCLES-1, so the first step comes STEP_CYCLES cycles after the seg_clear cycle.
- RUN step: seg_write=1, seg_shift=1, seg_data=buf[index].digit, seg_off=buf[index].blank; index increments.
  - After the step with index==msg_len-1: index=0 and go to PAD.
  - PAD count is set to GAP in loop mode, or 8 in one-shot mode.
- PAD step: seg_shift=1, seg_write=0 (shifts in an off digit); pad counter decrements.
  - When the counter reaches 0: loop -> RUN; one-shot -> IDLE, so the display ends blank.
  - PAD with GAP=0 in loop mode: go straight to RUN with no blank step.
- stop while busy: next cycle seg_clear=1, state IDLE, no step in that cycle even if a tick coincides. The buffer is preserved.
- stop in IDLE: ignored.
- start while busy: ignored.
- rst mid-operation: immediate return to reset values; no seg_clear pulse is generated.
- Exactly one of {seg_clear, seg_shift} is asserted per cycle at most. Strobes never occur in IDLE except the stop-clear pulse.

Test Plan:
- Reset and load (DEPTH=4): write 1,2,3 -> msg_len=3, buf_full=0. Write 4,5 -> msg_len=4, buf_full=1, 5 dropped.
- One-shot scroll (STEP_CYCLES=4, msg {A,B}): start -> seg_clear at T+1. Then write+shift A at T+5, B at T+9. Then 8 shift-only pulses every 4 cycles. busy falls after the 8th.
- Loop with GAP=2, msg {1, blank, 3}: sequence W1, Woff, W3, S, S, W1, ... repeats. Blank entry shows seg_off=1, seg_data=0.
- Stop coinciding with a tick: no step in that cycle; seg_clear next cycle; busy=0; msg_len unchanged. start again rescrolls from index 0.
- Ignored commands: start with msg_len=0, and wr_en/clear_msg/start while busy -> no strobes, msg_len unchanged. start+clear_msg together in IDLE -> scroll begins, buffer kept.
- Reset mid-PAD: all outputs 0 next cycle; msg_len=0; no further strobes.
